// File: rtl/ethernet_rx_ring_if.sv
// Signal bundle between the MAC receive stream, the packet read port and the
// receive ring; master is the MAC/controller side, slave is the ring.
interface ethernet_rx_ring_if #(
   parameter int data_width_p = 32,
   parameter int eth_mtu_p    = 2048,
   parameter int slots_p      = 4
);
   localparam int size_width_lp = $clog2(eth_mtu_p + 1);
   localparam int addr_width_lp = $clog2(eth_mtu_p);
   localparam int ptr_width_lp  = $clog2(slots_p) + 1;

   logic [data_width_p-1:0]   rx_axis_tdata_i;
   logic [data_width_p/8-1:0] rx_axis_tkeep_i;
   logic                      rx_axis_tvalid_i;
   logic                      rx_axis_tready_o;
   logic                      rx_axis_tlast_i;
   logic                      rx_axis_tuser_i;

   logic                      packet_avail_o;
   logic [size_width_lp-1:0]  packet_rsize_o;
   logic                      packet_rvalid_i;
   logic [addr_width_lp-1:0]  packet_raddr_i;
   logic [data_width_p-1:0]   packet_rdata_o;
   logic                      packet_ack_i;

   logic [ptr_width_lp-1:0]   rx_count_o;
   logic [15:0]               drop_count_o;
   logic                      drop_count_clear_i;

   modport master (
      output rx_axis_tdata_i, rx_axis_tkeep_i, rx_axis_tvalid_i,
             rx_axis_tlast_i, rx_axis_tuser_i,
             packet_rvalid_i, packet_raddr_i, packet_ack_i, drop_count_clear_i,
      input  rx_axis_tready_o, packet_avail_o, packet_rsize_o, packet_rdata_o,
             rx_count_o, drop_count_o
   );

   modport slave (
      input  rx_axis_tdata_i, rx_axis_tkeep_i, rx_axis_tvalid_i,
             rx_axis_tlast_i, rx_axis_tuser_i,
             packet_rvalid_i, packet_raddr_i, packet_ack_i, drop_count_clear_i,
      output rx_axis_tready_o, packet_avail_o, packet_rsize_o, packet_rdata_o,
             rx_count_o, drop_count_o
   );
endinterface

// File: rtl/ethernet_rx_ring.sv
// Ring of frame slots between the MAC receive stream and the packet read port.
// Bad, oversize and ring-full frames are discarded whole and counted.
module ethernet_rx_ring #(
   parameter int data_width_p = 32,
   parameter int eth_mtu_p    = 2048,
   parameter int slots_p      = 4
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   ethernet_rx_ring_if.slave bus
);
   localparam int bytes_lp      = data_width_p / 8;
   localparam int boff_lp       = $clog2(bytes_lp);
   localparam int size_width_lp = $clog2(eth_mtu_p + 1);
   localparam int addr_width_lp = $clog2(eth_mtu_p);
   localparam int ptr_width_lp  = $clog2(slots_p) + 1;
   localparam int slot_width_lp = ptr_width_lp - 1;
   localparam int word_width_lp = addr_width_lp - boff_lp;
   localparam int words_lp      = slots_p * (eth_mtu_p / bytes_lp);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_DROP
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic                      r_ready;
   logic [ptr_width_lp-1:0]   r_wp;
   logic [ptr_width_lp-1:0]   r_rp;
   logic [ptr_width_lp-1:0]   w_count;
   logic [size_width_lp-1:0]  r_cnt;
   logic [size_width_lp-1:0]  w_cnt_next;
   logic [size_width_lp-1:0]  w_pop;
   logic [size_width_lp-1:0]  w_sum;
   logic [word_width_lp-1:0]  r_idx;
   logic [word_width_lp-1:0]  w_idx_next;
   logic [word_width_lp-1:0]  w_widx;
   logic [slot_width_lp-1:0]  w_wslot;
   logic [slot_width_lp-1:0]  w_rslot;
   logic                      w_beat;
   logic                      w_full;
   logic                      w_avail;
   logic                      w_ack;
   logic                      w_mem_we;
   logic                      w_commit;
   logic                      w_drop;
   logic [15:0]               r_drop_count;
   logic [data_width_p-1:0]   r_mem [words_lp];
   logic [data_width_p-1:0]   r_rdata;
   logic [size_width_lp-1:0]  w_size [slots_p];
   logic                      w_unused_raddr;

   assign w_beat  = bus.rx_axis_tvalid_i & r_ready;
   assign w_count = r_wp - r_rp;
   assign w_full  = (w_count == ptr_width_lp'(slots_p));
   assign w_avail = (w_count != '0);
   assign w_ack   = bus.packet_ack_i & w_avail;
   assign w_wslot = r_wp[slot_width_lp-1:0];
   assign w_rslot = r_rp[slot_width_lp-1:0];

   // Read addresses are word granular; the byte-lane bits carry no information.
   assign w_unused_raddr = ^bus.packet_raddr_i[boff_lp-1:0];

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < bytes_lp; i++) begin
         w_pop = w_pop + size_width_lp'(bus.rx_axis_tkeep_i[i]);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_idx_next   = r_idx;
      w_mem_we     = 1'b0;
      w_commit     = 1'b0;
      w_drop       = 1'b0;
      w_sum        = r_cnt + w_pop;
      unique case (r_state)
         ST_IDLE: begin
            if (w_beat) begin
               // Fullness is judged here only; a same-cycle ack frees the slot too late.
               if (w_full) begin
                  if (bus.rx_axis_tlast_i) begin
                     w_drop = 1'b1;
                  end else begin
                     w_state_next = ST_DROP;
                  end
               end else begin
                  w_mem_we   = 1'b1;
                  w_cnt_next = w_pop;
                  w_idx_next = word_width_lp'(1);
                  if (bus.rx_axis_tlast_i) begin
                     w_drop   = bus.rx_axis_tuser_i;
                     w_commit = ~bus.rx_axis_tuser_i;
                  end else begin
                     w_state_next = ST_RECV;
                  end
               end
            end
         end
         ST_RECV: begin
            if (w_beat) begin
               if (w_sum > size_width_lp'(eth_mtu_p)) begin
                  if (bus.rx_axis_tlast_i) begin
                     w_drop       = 1'b1;
                     w_state_next = ST_IDLE;
                  end else begin
                     w_state_next = ST_DROP;
                  end
               end else begin
                  w_mem_we   = 1'b1;
                  w_cnt_next = w_sum;
                  w_idx_next = r_idx + word_width_lp'(1);
                  if (bus.rx_axis_tlast_i) begin
                     w_drop       = bus.rx_axis_tuser_i;
                     w_commit     = ~bus.rx_axis_tuser_i;
                     w_state_next = ST_IDLE;
                  end
               end
            end
         end
         ST_DROP: begin
            if (w_beat && bus.rx_axis_tlast_i) begin
               w_drop       = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_ready <= 1'b0;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
      end else begin
         r_ready <= 1'b1;
         r_cnt   <= w_cnt_next;
         r_idx   <= w_idx_next;
         if (w_commit) begin
            r_wp <= r_wp + ptr_width_lp'(1);
         end
         if (w_ack) begin
            r_rp <= r_rp + ptr_width_lp'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_drop_count <= '0;
      end else if (bus.drop_count_clear_i) begin
         r_drop_count <= '0;
      end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
         r_drop_count <= r_drop_count + 16'd1;
      end
   end

   // First beat of a frame always lands at word 0 of the write slot.
   assign w_widx = (r_state == ST_IDLE) ? '0 : r_idx;

   always_ff @(posedge clk_i) begin
      if (w_mem_we) begin
         r_mem[{w_wslot, w_widx}] <= bus.rx_axis_tdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_rdata <= '0;
      end else if (bus.packet_rvalid_i) begin
         r_rdata <= r_mem[{w_rslot, bus.packet_raddr_i[addr_width_lp-1:boff_lp]}];
      end
   end

   generate
      for (genvar gi = 0; gi < slots_p; gi++) begin : g_slot
         logic [size_width_lp-1:0] r_size;
         always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
               r_size <= '0;
            end else if (w_commit && (w_wslot == slot_width_lp'(gi))) begin
               r_size <= w_cnt_next;
            end
         end
         assign w_size[gi] = r_size;
      end
   endgenerate

   assign bus.rx_axis_tready_o = r_ready;
   assign bus.packet_avail_o   = w_avail;
   assign bus.packet_rsize_o   = w_avail ? w_size[w_rslot] : '0;
   assign bus.packet_rdata_o   = r_rdata;
   assign bus.rx_count_o       = w_count;
   assign bus.drop_count_o     = r_drop_count;
endmodule

// File: tb/tb_ethernet_rx_ring.sv
// Directed bench for ethernet_rx_ring: a frame-level queue model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_ethernet_rx_ring;
   localparam int DW    = 32;
   localparam int MTU   = 2048;
   localparam int SLOTS = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   ethernet_rx_ring_if #(.data_width_p(DW), .eth_mtu_p(MTU), .slots_p(SLOTS)) bus ();

   ethernet_rx_ring #(.data_width_p(DW), .eth_mtu_p(MTU), .slots_p(SLOTS)) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: committed frames as a queue of storage indices, whole-frame drop rules.
   int          m_q[$];
   int          m_size [SLOTS];
   logic [7:0]  m_frame [SLOTS][MTU];
   logic [7:0]  m_buf [MTU];
   int          m_commits = 0;
   int          m_len = 0;
   int          m_beats = 0;
   int          m_drop = 0;
   bit          m_in = 0;
   bit          m_start_full = 0;
   bit          m_ready = 0;
   logic [31:0] m_rdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] head_word(input int addr);
      int s;
      int a;
      s = m_q[0];
      a = addr & ~3;
      return {m_frame[s][a+3], m_frame[s][a+2], m_frame[s][a+1], m_frame[s][a]};
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_drop       = 0;
      m_ready      = 0;
      m_in         = 0;
      m_commits    = 0;
      m_rdata      = '0;
   endtask

   task automatic model_step();
      int cnt;
      bit ack_ok;
      bit full_now;
      bit drop_ev;
      cnt      = m_q.size();
      ack_ok   = bus.packet_ack_i && (cnt != 0);
      full_now = (cnt == SLOTS);
      drop_ev  = 0;
      if (bus.packet_rvalid_i && cnt != 0) m_rdata = head_word(int'(bus.packet_raddr_i));
      if (m_ready && bus.rx_axis_tvalid_i) begin
         int base;
         if (!m_in) begin
            m_in         = 1;
            m_len        = 0;
            m_beats      = 0;
            m_start_full = full_now;
         end
         base = m_beats * 4;
         for (int k = 0; k < 4; k++) begin
            if (base + k < MTU) m_buf[base+k] = bus.rx_axis_tdata_i[8*k +: 8];
         end
         m_len += $countones(bus.rx_axis_tkeep_i);
         m_beats++;
         if (bus.rx_axis_tlast_i) begin
            m_in = 0;
            if (m_start_full || bus.rx_axis_tuser_i || m_len > MTU) begin
               drop_ev = 1;
            end else begin
               int s;
               s = m_commits % SLOTS;
               for (int i = 0; i < MTU; i++) m_frame[s][i] = m_buf[i];
               m_size[s] = m_len;
               m_q.push_back(s);
               m_commits++;
            end
         end
      end
      if (ack_ok) void'(m_q.pop_front());
      if (bus.drop_count_clear_i) m_drop = 0;
      else if (drop_ev && m_drop < 65535) m_drop++;
      m_ready = 1;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("cyc_tready", 32'(bus.rx_axis_tready_o), 32'(m_ready));
         chk("cyc_avail", 32'(bus.packet_avail_o), 32'(m_q.size() != 0));
         chk("cyc_rx_count", 32'(bus.rx_count_o), 32'(m_q.size()));
         chk("cyc_rsize", 32'(bus.packet_rsize_o), (m_q.size() != 0) ? 32'(m_size[m_q[0]]) : 32'd0);
         chk("cyc_drop_count", 32'(bus.drop_count_o), 32'(m_drop));
         chk("cyc_rdata", bus.packet_rdata_o, m_rdata);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int f, input int nbytes, input bit bad,
                             input int ack_beat, input int clr_beat);
      int nb;
      nb = (nbytes + 3) / 4;
      $display("frame %0d bytes %0d bad %0d", f, nbytes, bad);
      for (int b = 0; b < nb; b++) begin
         int rem;
         rem = nbytes - b * 4;
         bus.rx_axis_tvalid_i   = 1'b1;
         bus.rx_axis_tdata_i    = {f[7:0], b[7:0], ~b[7:0], 8'h5A};
         bus.rx_axis_tkeep_i    = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
         bus.rx_axis_tlast_i    = (b == nb - 1);
         bus.rx_axis_tuser_i    = bad && (b == nb - 1);
         bus.packet_ack_i       = (b == ack_beat);
         bus.drop_count_clear_i = (b == clr_beat);
         tick(1);
      end
      bus.rx_axis_tvalid_i   = 1'b0;
      bus.rx_axis_tlast_i    = 1'b0;
      bus.rx_axis_tuser_i    = 1'b0;
      bus.packet_ack_i       = 1'b0;
      bus.drop_count_clear_i = 1'b0;
   endtask

   task automatic do_read(input int addr);
      bus.packet_rvalid_i = 1'b1;
      bus.packet_raddr_i  = 11'(addr);
      tick(1);
      bus.packet_rvalid_i = 1'b0;
      $display("read addr %0d data 0x%08h", addr, bus.packet_rdata_o);
   endtask

   task automatic do_ack();
      bus.packet_ack_i = 1'b1;
      tick(1);
      bus.packet_ack_i = 1'b0;
      $display("ack rx_count %0d", bus.rx_count_o);
   endtask

   initial begin
      bus.rx_axis_tdata_i    = '0;
      bus.rx_axis_tkeep_i    = '0;
      bus.rx_axis_tvalid_i   = 1'b0;
      bus.rx_axis_tlast_i    = 1'b0;
      bus.rx_axis_tuser_i    = 1'b0;
      bus.packet_rvalid_i    = 1'b0;
      bus.packet_raddr_i     = '0;
      bus.packet_ack_i       = 1'b0;
      bus.drop_count_clear_i = 1'b0;
      #1 rst_n = 1'b0;
      tick(3);
      chk("rst_tready", 32'(bus.rx_axis_tready_o), 32'd0);
      chk("rst_rx_count", 32'(bus.rx_count_o), 32'd0);
      rst_n = 1'b1;
      tick(2);
      chk("tready_up", 32'(bus.rx_axis_tready_o), 32'd1);

      // Single 64-byte frame
      send_frame(1, 64, 0, -1, -1);
      chk("single_avail", 32'(bus.packet_avail_o), 32'd1);
      chk("single_rsize", 32'(bus.packet_rsize_o), 32'd64);
      do_read(4);
      chk("single_read4", bus.packet_rdata_o, 32'h0101FE5A);
      do_read(7);
      chk("single_read7", bus.packet_rdata_o, 32'h0101FE5A);
      do_ack();
      chk("single_acked", 32'(bus.rx_count_o), 32'd0);

      // Odd length
      send_frame(2, 61, 0, -1, -1);
      chk("odd_rsize", 32'(bus.packet_rsize_o), 32'd61);
      do_read(60);
      chk("odd_last_word", bus.packet_rdata_o, 32'h020FF05A);
      do_ack();

      // Full ring; ack on the first beat of the overflow frame does not rescue it
      send_frame(3, 8, 0, -1, -1);
      send_frame(4, 12, 0, -1, -1);
      send_frame(5, 40, 0, -1, -1);
      send_frame(6, 4, 0, -1, -1);
      chk("full_count", 32'(bus.rx_count_o), 32'd4);
      send_frame(7, 8, 0, 0, -1);
      chk("full_drop", 32'(bus.drop_count_o), 32'd1);
      chk("full_after_ack", 32'(bus.rx_count_o), 32'd3);
      send_frame(8, 20, 0, -1, -1);
      chk("wrap_count", 32'(bus.rx_count_o), 32'd4);
      chk("wrap_head_rsize", 32'(bus.packet_rsize_o), 32'd12);
      do_ack();
      do_ack();
      do_ack();
      chk("wrap_new_rsize", 32'(bus.packet_rsize_o), 32'd20);
      do_read(0);
      chk("wrap_read0", bus.packet_rdata_o, 32'h0800FF5A);
      do_ack();
      do_ack();
      chk("ack_empty", 32'(bus.rx_count_o), 32'd0);

      // Bad frame, oversize frame, then good and exactly-MTU frames
      send_frame(9, 16, 1, -1, -1);
      chk("bad_drop", 32'(bus.drop_count_o), 32'd2);
      send_frame(10, 2052, 0, -1, -1);
      chk("oversize_drop", 32'(bus.drop_count_o), 32'd3);
      chk("oversize_count", 32'(bus.rx_count_o), 32'd0);
      send_frame(11, 24, 0, -1, -1);
      chk("after_bad_rsize", 32'(bus.packet_rsize_o), 32'd24);
      do_read(20);
      chk("after_bad_read", bus.packet_rdata_o, 32'h0B05FA5A);
      send_frame(12, 2048, 0, -1, -1);
      chk("mtu_count", 32'(bus.rx_count_o), 32'd2);
      do_ack();
      chk("mtu_rsize", 32'(bus.packet_rsize_o), 32'd2048);
      do_read(2044);
      chk("mtu_last_word", bus.packet_rdata_o, 32'h0CFF005A);
      do_ack();

      // Commit with ack in the same cycle; clear with drop in the same cycle
      send_frame(13, 8, 0, -1, -1);
      send_frame(14, 16, 0, 3, -1);
      chk("commit_ack_count", 32'(bus.rx_count_o), 32'd1);
      chk("commit_ack_rsize", 32'(bus.packet_rsize_o), 32'd16);
      do_ack();
      send_frame(15, 8, 1, -1, 1);
      chk("clear_vs_drop", 32'(bus.drop_count_o), 32'd0);

      // Saturate the drop counter with back-to-back single-beat bad frames
      $display("burst of 65535 single-beat bad frames");
      bus.rx_axis_tvalid_i = 1'b1;
      bus.rx_axis_tkeep_i  = 4'hF;
      bus.rx_axis_tlast_i  = 1'b1;
      bus.rx_axis_tuser_i  = 1'b1;
      tick(65535);
      bus.rx_axis_tvalid_i = 1'b0;
      bus.rx_axis_tlast_i  = 1'b0;
      bus.rx_axis_tuser_i  = 1'b0;
      chk("sat_reach", 32'(bus.drop_count_o), 32'hFFFF);
      send_frame(16, 4, 1, -1, -1);
      chk("sat_hold", 32'(bus.drop_count_o), 32'hFFFF);
      bus.drop_count_clear_i = 1'b1;
      tick(1);
      bus.drop_count_clear_i = 1'b0;
      chk("clear_alone", 32'(bus.drop_count_o), 32'd0);

      // Asynchronous reset in the middle of a frame with two frames committed
      send_frame(17, 8, 0, -1, -1);
      send_frame(18, 12, 0, -1, -1);
      send_frame(20, 4, 1, -1, -1);
      do_read(0);
      chk("pre_rst_read", bus.packet_rdata_o, 32'h1100FF5A);
      chk("pre_rst_count", 32'(bus.rx_count_o), 32'd2);
      for (int b = 0; b < 3; b++) begin
         bus.rx_axis_tvalid_i = 1'b1;
         bus.rx_axis_tkeep_i  = 4'hF;
         bus.rx_axis_tdata_i  = {8'h13, b[7:0], ~b[7:0], 8'h5A};
         tick(1);
      end
      #3 rst_n = 1'b0;
      bus.rx_axis_tvalid_i = 1'b0;
      #1;
      chk("arst_tready", 32'(bus.rx_axis_tready_o), 32'd0);
      chk("arst_avail", 32'(bus.packet_avail_o), 32'd0);
      chk("arst_count", 32'(bus.rx_count_o), 32'd0);
      chk("arst_rsize", 32'(bus.packet_rsize_o), 32'd0);
      chk("arst_rdata", bus.packet_rdata_o, 32'd0);
      chk("arst_drop", 32'(bus.drop_count_o), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      send_frame(21, 12, 0, -1, -1);
      chk("post_rst_count", 32'(bus.rx_count_o), 32'd1);
      chk("post_rst_rsize", 32'(bus.packet_rsize_o), 32'd12);
      do_read(8);
      chk("post_rst_read", bus.packet_rdata_o, 32'h1502FD5A);
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
